rf_write_arbiter: RTL

//  Shares the datapath register-file write port between the animation sequencing FSM and a host

---
 rtl/rf_write_arbiter_pkg.sv | 26 ++
 rtl/rf_write_arbiter_fifo.sv | 53 +++++
 rtl/rf_write_arbiter.sv | 100 ++++++++++
 3 files changed

// File: rtl/rf_write_arbiter_pkg.sv
// Register-file constants and host-write record shared by the write arbiter,
// the animation FSM and the datapath.
package rf_write_arbiter_pkg;

    localparam int unsigned RF_AW = 3;
    localparam int unsigned RF_DW = 32;

    localparam logic [RF_AW-1:0] REG_LEDS    = 3'd0;
    localparam logic [RF_AW-1:0] REG_BOUND   = 3'd1;
    localparam logic [RF_AW-1:0] REG_COUNTER = 3'd2;
    localparam logic [RF_AW-1:0] REG_MASK    = 3'd3;
    localparam logic [RF_AW-1:0] REG_SHIFT   = 3'd4;

    typedef struct packed {
        logic [RF_AW-1:0] addr;
        logic [RF_DW-1:0] data;
    } cfg_wr_t;

    localparam int unsigned CFG_WR_W = $bits(cfg_wr_t);

    function automatic logic addr_protected(input logic [2**RF_AW-1:0] mask,
                                            input logic [RF_AW-1:0]    addr);
        return mask[addr];
    endfunction

endpackage

// File: rtl/rf_write_arbiter_fifo.sv
// Small synchronous FIFO for queued host writes; occupancy counter carries one
// extra bit so full and empty are distinguishable when the pointers coincide.
module cfg_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 35
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [PW:0]      count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign dout    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: FSM writes pass straight through, queued
// host configuration writes fill idle slots, protected addresses are rejected.
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int unsigned           DEPTH        = 2,
    parameter int unsigned           MAX_WAIT     = 1024,
    parameter logic [2**RF_AW-1:0]   PROTECT_MASK = 8'h01
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fsm_we,
    input  logic [RF_AW-1:0]         fsm_wa,
    input  logic [RF_DW-1:0]         fsm_wd,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic [RF_AW-1:0]         cfg_addr,
    input  logic [RF_DW-1:0]         cfg_data,
    output logic                     cfg_err,
    output logic                     rf_we,
    output logic [RF_AW-1:0]         rf_wa,
    output logic [RF_DW-1:0]         rf_wd,
    output logic [$clog2(DEPTH):0]   cfg_pending,
    output logic                     cfg_timeout
);

    localparam int unsigned WW = $clog2(MAX_WAIT + 1);
    localparam logic [WW-1:0] WAIT_SAT = WW'(MAX_WAIT);

    cfg_wr_t       head, tail;
    logic          fifo_full, fifo_empty;
    logic          accept, prot, push, pop;
    logic          err_q, err_d;
    logic          timeout_q, timeout_d;
    logic [WW-1:0] wait_q, wait_d;

    assign cfg_ready = ~fifo_full;
    assign accept    = cfg_valid & cfg_ready;
    assign prot      = addr_protected(PROTECT_MASK, cfg_addr);
    assign push      = accept & ~prot;
    assign pop       = ~fsm_we & ~fifo_empty;
    assign tail      = '{addr: cfg_addr, data: cfg_data};

    cfg_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CFG_WR_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (tail),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (cfg_pending)
    );

    always_comb begin
        rf_we = 1'b0;
        rf_wa = '0;
        rf_wd = '0;
        if (fsm_we) begin
            rf_we = 1'b1;
            rf_wa = fsm_wa;
            rf_wd = fsm_wd;
        end else if (!fifo_empty) begin
            rf_we = 1'b1;
            rf_wa = head.addr;
            rf_wd = head.data;
        end
    end

    // Timeout is set from the next count so it shows on the edge the count saturates.
    always_comb begin
        wait_d = wait_q;
        if (fifo_empty || pop)
            wait_d = '0;
        else if (fsm_we && wait_q != WAIT_SAT)
            wait_d = wait_q + 1'b1;
        timeout_d = timeout_q | (wait_d == WAIT_SAT);
        err_d     = accept & prot;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_q    <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            err_q     <= err_d;
        end
    end

    assign cfg_err     = err_q;
    assign cfg_timeout = timeout_q;

endmodule
